// File: rtl/sprite_frame_sequencer.sv
// sprite_frame_sequencer: per-frame erase/move/draw of a bouncing box on the VGA pixel port.
// Define CLEAR_ON_RESET_EN to sweep the whole screen black after reset before the first frame.
module sprite_frame_sequencer #(
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int TICK_DIV = 833333
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] speed,
    input  logic [2:0] colour_in,
    input  logic       pause,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);
    localparam int N  = BOX_W * BOX_H;
    localparam int KW = $clog2(N);
    localparam int XW = $clog2(BOX_W);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ERASE = 3'd1;
    localparam logic [2:0] MOVE  = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - BOX_W);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - BOX_H);

    logic [2:0]    state, state_n, step_cnt, col_r;
    logic [TW-1:0] tick_cnt;
    logic [KW-1:0] k, k_n;
    logic [7:0]    pos_x, px_n;
    logic [6:0]    pos_y, py_n;
    logic          dir_x, dir_y, dx_n, dy_n;
    logic          tick, step, upd, bx, by, pn;

    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    assign step = step_cnt >= speed;
    assign upd  = state == MOVE && step;
    // Bounce: flip direction first when the step would leave the legal range.
    assign bx   = dir_x ? pos_x == X_MAX : pos_x == 8'd0;
    assign by   = dir_y ? pos_y == Y_MAX : pos_y == 7'd0;
    assign dx_n = upd ? dir_x ^ bx : dir_x;
    assign dy_n = upd ? dir_y ^ by : dir_y;
    assign px_n = upd ? (dx_n ? pos_x + 8'd1 : pos_x - 8'd1) : pos_x;
    assign py_n = upd ? (dy_n ? pos_y + 7'd1 : pos_y - 7'd1) : pos_y;
    assign k_n  = state_n == state ? k + KW'(1) : '0;

`ifdef CLEAR_ON_RESET_EN
    localparam logic [2:0] CLEAR = 3'd5;
    logic [7:0] cx;
    logic [6:0] cy;
    assign pn = state_n == ERASE || state_n == DRAW || state_n == CLEAR;
`else
    assign pn = state_n == ERASE || state_n == DRAW;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = tick && !pause ? ERASE : IDLE;
            ERASE:   state_n = k == KW'(N - 1) ? MOVE : ERASE;
            MOVE:    state_n = DRAW;
            DRAW:    state_n = k == KW'(N - 1) ? DONE : DRAW;
            DONE:    state_n = IDLE;
`ifdef CLEAR_ON_RESET_EN
            CLEAR:   state_n = cy == 7'(SCREEN_H) ? IDLE : CLEAR;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so plot lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!resetn) begin
`ifdef CLEAR_ON_RESET_EN
            state <= CLEAR;
            cx    <= 8'd0;
            cy    <= 7'd0;
`else
            state <= IDLE;
`endif
            tick_cnt   <= '0;
            step_cnt   <= 3'd0;
            k          <= '0;
            col_r      <= 3'd0;
            pos_x      <= 8'd0;
            pos_y      <= 7'd0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour_out <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
            state      <= state_n;
            k          <= k_n;
            pos_x      <= px_n;
            pos_y      <= py_n;
            dir_x      <= dx_n;
            dir_y      <= dy_n;
            if (state == MOVE) step_cnt <= step ? 3'd0 : step_cnt + 3'd1;
            if (state == IDLE && state_n == ERASE) col_r <= colour_in;
            plot       <= pn;
            busy       <= state_n != IDLE;
            frame_done <= state_n == DONE;
            if (pn) begin
                x_out      <= px_n + 8'(k_n[XW-1:0]);
                y_out      <= py_n + 7'(k_n[KW-1:XW]);
                colour_out <= state_n == DRAW ? col_r : 3'd0;
            end
`ifdef CLEAR_ON_RESET_EN
            if (state == CLEAR) begin
                cx <= cx == 8'(SCREEN_W - 1) ? 8'd0 : cx + 8'd1;
                cy <= cx == 8'(SCREEN_W - 1) ? cy + 7'd1 : cy;
            end
            if (state_n == CLEAR) begin
                x_out <= cx;
                y_out <= cy;
            end
`endif
        end
    end
endmodule
